// File: rtl/uart_pkg.sv
// Shared types for the framed UART transmitter: FSM states, parity modes and
// the data-width clamp applied when a frame starts.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  typedef enum logic [1:0] {
    ParNone    = 2'd0,
    ParEven    = 2'd1,
    ParOdd     = 2'd2,
    ParNoneAlt = 2'd3
  } parity_e;

  // Requests below five bits or above the synthesised width snap to the nearest limit.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < 4'd5) begin
      return 4'd5;
    end else if (req > max_bits) begin
      return max_bits;
    end else begin
      return req;
    end
  endfunction

  function automatic logic parity_enabled(input parity_e mode);
    return (mode == ParEven) || (mode == ParOdd);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact occupancy count; DEPTH must be a power of two so
// the pointers wrap on their own and the count MSB doubles as the full flag.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = 1;
  localparam logic [AW:0]   LevelOne = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = r_level[AW];
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LevelOne;
        2'b01:   r_level <= r_level - LevelOne;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// FIFO-fed UART transmitter with per-frame latched configuration (data width,
// parity, stop bits, baud divisor) and back-to-back framing.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned DIV_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic [MAX_DATA_BITS-1:0]      tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          tx_signal,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [3:0] MaxBits = 4'(MAX_DATA_BITS);
  localparam logic [DIV_WIDTH-1:0] DivOne = 1;

  tx_state_e                r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]     r_cnt, w_cnt_nxt;
  logic [DIV_WIDTH-1:0]     r_div_m1, w_div_m1_nxt;
  logic [DIV_WIDTH-1:0]     w_div_m1_in;
  logic [3:0]               r_bit_idx, w_bit_idx_nxt;
  logic [3:0]               r_nbits, w_nbits_nxt;
  logic [MAX_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                     r_par, w_par_nxt;
  parity_e                  r_par_mode, w_par_mode_nxt;
  logic                     r_stop2, w_stop2_nxt;
  logic                     r_stop_left, w_stop_left_nxt;
  logic                     r_tx, w_tx_nxt;

  logic                     w_start;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [MAX_DATA_BITS-1:0] w_fifo_data;

  assign tx_ready  = ena & ~w_fifo_full;
  assign w_push    = tx_valid & tx_ready;
  assign w_pop     = ena & w_start;
  assign tx_signal = r_tx;
  assign tx_busy   = (r_state != StIdle);

  // A divisor of zero is treated as one cycle per bit.
  assign w_div_m1_in = (cfg_div == '0) ? '0 : (cfg_div - DivOne);

  sync_fifo #(
    .WIDTH (MAX_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_div_m1_nxt    = r_div_m1;
    w_bit_idx_nxt   = r_bit_idx;
    w_nbits_nxt     = r_nbits;
    w_shift_nxt     = r_shift;
    w_par_nxt       = r_par;
    w_par_mode_nxt  = r_par_mode;
    w_stop2_nxt     = r_stop2;
    w_stop_left_nxt = r_stop_left;
    w_tx_nxt        = r_tx;
    w_start         = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_start = ~w_fifo_empty;
      end

      StStart: begin
        if (r_cnt == '0) begin
          w_state_nxt   = StData;
          w_cnt_nxt     = r_div_m1;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt - DivOne;
        end
      end

      StData: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = r_div_m1;
          w_par_nxt   = r_par ^ r_shift[0];
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == (r_nbits - 4'd1)) begin
            if (parity_enabled(r_par_mode)) begin
              w_state_nxt = StParity;
              w_tx_nxt    = r_par ^ r_shift[0] ^ (r_par_mode == ParOdd);
            end else begin
              w_state_nxt     = StStop;
              w_tx_nxt        = 1'b1;
              w_stop_left_nxt = r_stop2;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + 4'd1;
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt - DivOne;
        end
      end

      StParity: begin
        if (r_cnt == '0) begin
          w_state_nxt     = StStop;
          w_cnt_nxt       = r_div_m1;
          w_tx_nxt        = 1'b1;
          w_stop_left_nxt = r_stop2;
        end else begin
          w_cnt_nxt = r_cnt - DivOne;
        end
      end

      StStop: begin
        if (r_cnt == '0) begin
          if (r_stop_left) begin
            w_stop_left_nxt = 1'b0;
            w_cnt_nxt       = r_div_m1;
          end else if (!w_fifo_empty) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = StIdle;
          end
        end else begin
          w_cnt_nxt = r_cnt - DivOne;
        end
      end

      default: begin
        w_state_nxt = StIdle;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Frame start: pop the head word and snapshot the configuration for this frame.
    if (w_start) begin
      w_state_nxt     = StStart;
      w_tx_nxt        = 1'b0;
      w_shift_nxt     = w_fifo_data;
      w_par_nxt       = 1'b0;
      w_bit_idx_nxt   = '0;
      w_stop_left_nxt = 1'b0;
      w_nbits_nxt     = clamp_data_bits(cfg_data_bits, MaxBits);
      w_par_mode_nxt  = parity_e'(cfg_parity);
      w_stop2_nxt     = cfg_stop2;
      w_div_m1_nxt    = w_div_m1_in;
      w_cnt_nxt       = w_div_m1_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_div_m1    <= '0;
      r_bit_idx   <= '0;
      r_nbits     <= 4'd5;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_par_mode  <= ParNone;
      r_stop2     <= 1'b0;
      r_stop_left <= 1'b0;
      r_tx        <= 1'b1;
    end else if (ena) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div_m1    <= w_div_m1_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_nbits     <= w_nbits_nxt;
      r_shift     <= w_shift_nxt;
      r_par       <= w_par_nxt;
      r_par_mode  <= w_par_mode_nxt;
      r_stop2     <= w_stop2_nxt;
      r_stop_left <= w_stop_left_nxt;
      r_tx        <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: cycle-exact line checks against hand-built
// frame patterns (slot 0 = start bit, LSB of the pattern).
module tb_uart_tx_framed;

  logic        clk;
  logic        reset_n;
  logic        ena;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        tx_signal;
  logic        tx_busy;
  logic [2:0]  fifo_level;

  int          total;
  int          bad;
  int          accepts;
  bit          pend;
  logic [7:0]  push_q[$];

  uart_tx_framed #(
    .MAX_DATA_BITS (8),
    .FIFO_DEPTH    (4),
    .DIV_WIDTH     (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ena           (ena),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_signal     (tx_signal),
    .tx_busy       (tx_busy),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called once per negedge: retires an accepted word and presents the next queued one.
  task automatic push_tick();
    if (pend) begin
      accepts++;
      void'(push_q.pop_front());
    end
    if (push_q.size() > 0) begin
      tx_data  = push_q[0];
      tx_valid = 1'b1;
    end else begin
      tx_valid = 1'b0;
    end
    pend = tx_valid && tx_ready;
  endtask

  // Queue one word, check the idle line at the accepting edge, land on the start bit.
  task automatic start_one(input string tag, input logic [7:0] d);
    push_q.push_back(d);
    push_tick();
    @(negedge clk);
    push_tick();
    chk({tag, ".lvl1"}, fifo_level, 1);
    chk({tag, ".idle_tx"}, tx_signal, 1'b1);
    chk({tag, ".idle_busy"}, tx_busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int nslots, input logic [15:0] pat,
                           input int div, input int stall_slot);
    for (int s = 0; s < nslots; s++) begin
      for (int c = 0; c < div; c++) begin
        push_tick();
        if (s == stall_slot && c == 1) begin
          ena = 1'b0;
          #1;
          chk({tag, ".rdy_off"}, tx_ready, 1'b0);
          for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s.hold%0d", tag, k), tx_signal, pat[s]);
            @(negedge clk);
          end
          ena = 1'b1;
        end
        chk($sformatf("%s.s%0d.c%0d", tag, s, c), tx_signal, pat[s]);
        chk($sformatf("%s.busy.s%0d", tag, s), tx_busy, 1'b1);
        @(negedge clk);
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".end_tx"}, tx_signal, 1'b1);
    chk({tag, ".end_busy"}, tx_busy, 1'b0);
    chk({tag, ".end_lvl"}, fifo_level, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    accepts = 0;
    pend = 1'b0;
    reset_n = 1'b0;
    ena = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    cfg_div = 16'd4;
    cfg_data_bits = 4'd8;
    cfg_parity = 2'd0;
    cfg_stop2 = 1'b0;

    // Reset taken with ena low
    repeat (2) @(negedge clk);
    chk("rst_tx", tx_signal, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_rdy_ena0", tx_ready, 1'b0);
    reset_n = 1'b1;
    ena = 1'b1;
    #1;
    chk("rdy_ena1", tx_ready, 1'b1);
    @(negedge clk);

    // 8N1, div 4, 0xA5: 40 busy cycles
    start_one("8n1", 8'hA5);
    run_frame("8n1", 10, {6'b0, 1'b1, 8'hA5, 1'b0}, 4, -1);
    chk_idle("8n1");

    // 8E1, div 2: four ones in 0xA5 -> parity 0
    cfg_div = 16'd2;
    cfg_parity = 2'd1;
    start_one("8e1", 8'hA5);
    run_frame("8e1", 11, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 2, -1);
    chk_idle("8e1");

    // 8O1, div 2, with configuration scrambled after the frame has started
    cfg_parity = 2'd2;
    start_one("8o1", 8'hA5);
    cfg_div = 16'd7;
    cfg_parity = 2'd0;
    cfg_data_bits = 4'd5;
    cfg_stop2 = 1'b1;
    run_frame("8o1", 11, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 2, -1);
    chk_idle("8o1");

    // 7N2, div 3, 0x55: 30-cycle frame
    cfg_div = 16'd3;
    cfg_data_bits = 4'd7;
    cfg_parity = 2'd0;
    cfg_stop2 = 1'b1;
    start_one("7n2", 8'h55);
    run_frame("7n2", 10, {6'b0, 2'b11, 7'h55, 1'b0}, 3, -1);
    chk_idle("7n2");

    // div 0 acts as 1; data width 2 clamps to 5, 15 clamps to 8
    cfg_div = 16'd0;
    cfg_data_bits = 4'd2;
    cfg_stop2 = 1'b0;
    start_one("clamp_lo", 8'h13);
    run_frame("clamp_lo", 7, {9'b0, 1'b1, 5'h13, 1'b0}, 1, -1);
    chk_idle("clamp_lo");
    cfg_data_bits = 4'd15;
    start_one("clamp_hi", 8'h3C);
    run_frame("clamp_hi", 10, {6'b0, 1'b1, 8'h3C, 1'b0}, 1, -1);
    chk_idle("clamp_hi");

    // Six words into a 4-deep FIFO: five accepted, then contiguous frames in order
    cfg_div = 16'd2;
    cfg_data_bits = 4'd8;
    accepts = 0;
    push_q.push_back(8'h11);
    push_q.push_back(8'h22);
    push_q.push_back(8'h33);
    push_q.push_back(8'h44);
    push_q.push_back(8'h55);
    push_q.push_back(8'h66);
    push_tick();
    @(negedge clk);
    push_tick();
    chk("fifo.lvl1", fifo_level, 1);
    chk("fifo.rdy1", tx_ready, 1'b1);
    @(negedge clk);
    run_frame("fifo.f0", 10, {6'b0, 1'b1, 8'h11, 1'b0}, 2, -1);
    chk("fifo.accepts5", accepts, 5);
    chk("fifo.lvl3", fifo_level, 3);
    chk("fifo.rdy_back", tx_ready, 1'b1);
    run_frame("fifo.f1", 10, {6'b0, 1'b1, 8'h22, 1'b0}, 2, -1);
    run_frame("fifo.f2", 10, {6'b0, 1'b1, 8'h33, 1'b0}, 2, -1);
    run_frame("fifo.f3", 10, {6'b0, 1'b1, 8'h44, 1'b0}, 2, -1);
    run_frame("fifo.f4", 10, {6'b0, 1'b1, 8'h55, 1'b0}, 2, -1);
    run_frame("fifo.f5", 10, {6'b0, 1'b1, 8'h66, 1'b0}, 2, -1);
    chk("fifo.accepts6", accepts, 6);
    chk_idle("fifo");

    // ena low for 10 cycles during data bit 1 stretches that bit by exactly 10
    cfg_div = 16'd4;
    start_one("stall", 8'hA5);
    run_frame("stall", 10, {6'b0, 1'b1, 8'hA5, 1'b0}, 4, 2);
    chk_idle("stall");

    // Reset in the middle of a frame with two words still queued
    push_q.push_back(8'h00);
    push_q.push_back(8'h00);
    push_q.push_back(8'h00);
    push_tick();
    repeat (7) begin
      @(negedge clk);
      push_tick();
    end
    chk("mrst.pre_tx", tx_signal, 1'b0);
    chk("mrst.pre_lvl", fifo_level, 2);
    chk("mrst.pre_busy", tx_busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst.tx", tx_signal, 1'b1);
    chk("mrst.lvl", fifo_level, 0);
    chk("mrst.busy", tx_busy, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("mrst.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter MAX_DATA_BITS, default 8, meaning the widest data field supported (range 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the transmit FIFO depth in words (power of two, >=2).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, meaning the width of the baud divisor input.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled on clk.
REQ-006 SHALL have port ena, input, 1 bit: clock enable; when low, all state is held and no push is accepted.
REQ-007 SHALL have port tx_data, input, MAX_DATA_BITS bits: word to send; only the low cfg_data_bits bits are transmitted.
REQ-008 SHALL have port tx_valid, input, 1 bit: push request.
REQ-009 SHALL have port tx_ready, output, 1 bit: high when the FIFO is not full and ena=1; combinational.
REQ-010 SHALL have port cfg_div, input, DIV_WIDTH bits: clk cycles per bit; a value of 0 behaves as 1.
REQ-011 SHALL have port cfg_data_bits, input, 4 bits: data bits per frame; values outside 5..MAX_DATA_BITS clamp to the nearest limit.
REQ-012 SHALL have port cfg_parity, input, 2 bits: 0 = none, 1 = even, 2 = odd, 3 = none.
REQ-013 SHALL have port cfg_stop2, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-014 SHALL have port tx_signal, output, 1 bit: serial line, idle high, registered.
REQ-015 SHALL have port tx_busy, output, 1 bit: high while a frame is in progress.
REQ-016 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: number of words currently held in the FIFO.

Function
REQ-017 SHALL accept a push on a rising edge when tx_valid, tx_ready and ena are all 1; the word is written to the FIFO tail.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; all transitions are qualified by ena.
REQ-019 SHALL, from IDLE with FIFO non-empty, pop the head word on the next enabled edge, drive tx_signal=0, latch all cfg_* inputs for the frame and enter START; for a push into an empty idle block, the start bit appears one enabled edge after the accepting edge.
REQ-020 SHALL hold each bit for exactly max(cfg_div,1) enabled cycles, counted by a per-bit down-counter.
REQ-021 SHALL transmit data LSB-first in DATA, then enter PARITY if the latched parity mode is even or odd, else STOP.
REQ-022 SHALL make the parity bit the XOR of the transmitted data bits for even, and its inverse for odd.
REQ-023 SHALL drive 1 or 2 stop bits (high) in STOP, then enter IDLE; if the FIFO is non-empty at that edge, the next start bit begins on the same edge (back-to-back, no idle gap).
REQ-024 SHALL NOT let cfg_* changes mid-frame affect the current frame; they take effect from the next frame start.
REQ-025 SHALL not pop an empty FIFO; a push on the same edge as a pop when full is refused (tx_ready low).
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH; fifo_level is exact under simultaneous push and pop (unchanged).
REQ-027 SHALL assert tx_busy from the START entry edge until the edge leaving the final stop bit with the FIFO empty.

Reset
REQ-028 SHALL, on reset_n=0 at a rising edge, set tx_signal=1, tx_busy=0, fifo_level=0, FSM=IDLE, counters=0, and discard FIFO contents, regardless of ena.
REQ-029 SHALL, on reset mid-frame, abort the frame immediately; the line returns high on the reset edge.

Structure
REQ-030 SHALL place the FSM state enum, the parity-mode enum and its encodings in shared package uart_pkg.
REQ-031 SHALL instantiate one sub-module, sync_fifo, parametrised by width and depth with push, pop, full, empty and level ports.

Verification
REQ-032 8N1, cfg_div=4, push 0xA5 -> tx_signal 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_busy high for 40 cycles.
REQ-033 8E1 and 8O1, cfg_div=2, 0xA5 -> parity bit 0 (even) and 1 (odd) after the data bits; frame length 11 bits.
REQ-034 7N2, cfg_div=3, push 0x55 -> 7 data bits 1,0,1,0,1,0,1, then 2 stop bits; frame 30 cycles.
REQ-035 FIFO_DEPTH=4, push 6 words back-to-back -> tx_ready drops after 5 accepts (4 in FIFO + 1 popped), frames are contiguous with no idle gap, order preserved.
REQ-036 Drop ena for 10 cycles mid-DATA -> bit duration extends by exactly 10 cycles and tx_signal is held; reset mid-frame -> tx_signal=1 and fifo_level=0 on the next edge.
